// File: rtl/run_ctl_pkg.sv
// Shared types and constants for the run/halt sequencer.
package run_ctl_pkg;

    // Sequencer states: release the core, run the window, then dump registers.
    typedef enum logic [2:0] {
        INIT,
        RUN,
        RD,
        CAP,
        OUT,
        DONE
    } state_t;

    localparam int NREGS_DEF  = 16;
    localparam int REG_DATA_W = 32;

    // Width of an index able to address n registers (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int REG_IDX_W = idx_width(NREGS_DEF);

endpackage

// File: rtl/run_controller_if.sv
// Register-file read port and register-dump stream of the run controller.
interface run_controller_if #(
    parameter int IDX_W  = run_ctl_pkg::REG_IDX_W,
    parameter int DATA_W = run_ctl_pkg::REG_DATA_W
);
    logic [IDX_W-1:0]  reg_idx;
    logic              reg_rd_en;
    logic [DATA_W-1:0] reg_data;
    logic              dump_valid;
    logic              dump_ready;
    logic [IDX_W-1:0]  dump_idx;
    logic [DATA_W-1:0] dump_data;

    // Controller side: issues reads and sources dump beats.
    modport master (
        output reg_idx, reg_rd_en, dump_valid, dump_idx, dump_data,
        input  reg_data, dump_ready
    );

    // Environment side: register file plus dump sink.
    modport slave (
        input  reg_idx, reg_rd_en, dump_valid, dump_idx, dump_data,
        output reg_data, dump_ready
    );
endinterface

// File: rtl/run_controller_sat_counter.sv
// Saturating up-counter with synchronous reset and count enable.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count
);

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
        return (&v) ? v : v + W'(1);
    endfunction

    // Count enabled cycles, clear on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            count <= sat_inc(count);
        end
    end

endmodule

// File: rtl/run_controller.sv
// Run/halt sequencer for the Tenyr core: releases reset and halt, runs a
// fixed window while counting cycles and retired instructions, then freezes
// the core and streams the register file out over a valid/ready port.
module run_controller
    import run_ctl_pkg::*;
#(
    parameter int RESET_CYCLES = 3,
    parameter int HALT_CYCLES  = 4,
    parameter int PERIODS      = 64,
    parameter int NREGS        = 16,
    parameter int CNTW         = 32,
    parameter bit DUMP_EN      = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            retire,
    output logic            core_reset,
    output logic            core_halt,
    run_controller_if.master bus,
    output logic [CNTW-1:0] cycle_count,
    output logic [CNTW-1:0] insn_count,
    output logic            done
);

    localparam int IW = REG_IDX_W;
    localparam int PW = (PERIODS > 1) ? $clog2(PERIODS) : 1;

    state_t        state;
    logic [PW-1:0] phase_cnt;
    logic          at_end;
    logic          rst_nx;
    logic          halt_nx;
    logic          last_reg;
    logic          cyc_en;
    logic          insn_en;

    // The core control outputs are registered, so they are derived from the
    // phase the counter is about to take, keeping them aligned to cycle number.
    assign at_end   = (int'(phase_cnt) == PERIODS - 1);
    assign rst_nx   = (int'(phase_cnt) + 1 < RESET_CYCLES);
    assign halt_nx  = (int'(phase_cnt) + 1 < HALT_CYCLES);
    assign last_reg = (bus.reg_idx == IW'(NREGS - 1));

    assign cyc_en  = (state == INIT) || (state == RUN);
    assign insn_en = retire && (state == RUN) && !core_reset && !core_halt;

    // Sequencer FSM with all outputs registered; reg_idx doubles as the dump index.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= INIT;
            phase_cnt      <= '0;
            core_reset     <= 1'b1;
            core_halt      <= 1'b1;
            bus.reg_rd_en  <= 1'b0;
            bus.reg_idx    <= '0;
            bus.dump_valid <= 1'b0;
            bus.dump_idx   <= '0;
            bus.dump_data  <= '0;
            done           <= 1'b0;
        end else begin
            bus.reg_rd_en <= 1'b0;
            case (state)
                INIT, RUN: begin
                    if (at_end) begin
                        // Window over: freeze the core, even if it was never released.
                        core_reset <= 1'b0;
                        core_halt  <= 1'b1;
                        if (DUMP_EN) begin
                            state         <= RD;
                            bus.reg_rd_en <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end else begin
                        phase_cnt  <= phase_cnt + PW'(1);
                        core_reset <= rst_nx;
                        core_halt  <= halt_nx;
                        if (!rst_nx && !halt_nx) begin
                            state <= RUN;
                        end
                    end
                end
                RD: begin
                    state <= CAP;
                end
                CAP: begin
                    bus.dump_data  <= bus.reg_data;
                    bus.dump_idx   <= bus.reg_idx;
                    bus.dump_valid <= 1'b1;
                    state          <= OUT;
                end
                OUT: begin
                    if (bus.dump_ready) begin
                        bus.dump_valid <= 1'b0;
                        if (last_reg) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            bus.reg_idx   <= bus.reg_idx + IW'(1);
                            bus.reg_rd_en <= 1'b1;
                            state         <= RD;
                        end
                    end
                end
                DONE: begin
                    done <= 1'b1;
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

    sat_counter #(.W(CNTW)) u_cycle_cnt (
        .clk   (clk),
        .rst   (reset),
        .en    (cyc_en),
        .count (cycle_count)
    );

    sat_counter #(.W(CNTW)) u_insn_cnt (
        .clk   (clk),
        .rst   (reset),
        .en    (insn_en),
        .count (insn_count)
    );

endmodule

// File: tb/tb_run_controller.sv
// Directed bench for run_controller: default build, a narrow-counter build
// without dump, and a short-window build whose core is never released.
module tb_run_controller;

    logic clk = 1'b0;
    logic reset;
    logic retire;

    logic        core_reset0, core_halt0, done0;
    logic [31:0] cc0, ic0;
    logic        core_reset1, core_halt1, done1;
    logic [3:0]  cc1, ic1;
    logic        core_reset2, core_halt2, done2;
    logic [31:0] cc2, ic2;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    run_controller_if bus0 ();
    run_controller_if bus1 ();
    run_controller_if bus2 ();

    always #5 clk = ~clk;

    run_controller dut0 (
        .clk(clk), .reset(reset), .retire(retire),
        .core_reset(core_reset0), .core_halt(core_halt0), .bus(bus0),
        .cycle_count(cc0), .insn_count(ic0), .done(done0)
    );

    run_controller #(.CNTW(4), .DUMP_EN(1'b0)) dut1 (
        .clk(clk), .reset(reset), .retire(retire),
        .core_reset(core_reset1), .core_halt(core_halt1), .bus(bus1),
        .cycle_count(cc1), .insn_count(ic1), .done(done1)
    );

    run_controller #(.PERIODS(3), .NREGS(2)) dut2 (
        .clk(clk), .reset(reset), .retire(retire),
        .core_reset(core_reset2), .core_halt(core_halt2), .bus(bus2),
        .cycle_count(cc2), .insn_count(ic2), .done(done2)
    );

    // Register-file model: data 0x1000+idx returned the cycle after the read strobe.
    always @(posedge clk) begin
        if (bus0.reg_rd_en) bus0.reg_data <= 32'h1000 + 32'(bus0.reg_idx);
        if (bus2.reg_rd_en) bus2.reg_data <= 32'h1000 + 32'(bus2.reg_idx);
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Leaves the bench sampling cycle 0 (first cycle with reset low).
    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_cmp++; if (core_reset0 !== 1'b1) begin n_bad++; $display("FAIL rst_core_reset got=%b exp=1", core_reset0); end
        n_cmp++; if (core_halt0 !== 1'b1) begin n_bad++; $display("FAIL rst_core_halt got=%b exp=1", core_halt0); end
        n_cmp++; if (bus0.reg_rd_en !== 1'b0) begin n_bad++; $display("FAIL rst_reg_rd_en got=%b exp=0", bus0.reg_rd_en); end
        n_cmp++; if (bus0.reg_idx !== 4'd0) begin n_bad++; $display("FAIL rst_reg_idx got=%0d exp=0", bus0.reg_idx); end
        n_cmp++; if (bus0.dump_valid !== 1'b0) begin n_bad++; $display("FAIL rst_dump_valid got=%b exp=0", bus0.dump_valid); end
        n_cmp++; if (bus0.dump_idx !== 4'd0) begin n_bad++; $display("FAIL rst_dump_idx got=%0d exp=0", bus0.dump_idx); end
        n_cmp++; if (bus0.dump_data !== 32'd0) begin n_bad++; $display("FAIL rst_dump_data got=%h exp=0", bus0.dump_data); end
        n_cmp++; if (cc0 !== 32'd0) begin n_bad++; $display("FAIL rst_cycle_count got=%0d exp=0", cc0); end
        n_cmp++; if (ic0 !== 32'd0) begin n_bad++; $display("FAIL rst_insn_count got=%0d exp=0", ic0); end
        n_cmp++; if (done0 !== 1'b0) begin n_bad++; $display("FAIL rst_done got=%b exp=0", done0); end
        n_cmp++; if (cc1 !== 4'd0 || done1 !== 1'b0) begin n_bad++; $display("FAIL rst_dut1 got cc=%0d done=%b exp 0/0", cc1, done1); end
        reset = 1'b0;
        cyc = 0;
    endtask

    // Whole default run from cycle 0, retire and dump_ready held high.
    task automatic test_full_run(input string tag);
        logic       e_rst, e_halt, e_rd, e_vld, e_done;
        int         e_cc, e_ic, e_idx;
        retire = 1'b1;
        bus0.dump_ready = 1'b1;
        for (int c = 0; c <= 115; c++) begin
            e_rst  = (c < 3);
            e_halt = (c < 4) || (c >= 64);
            e_rd   = (c >= 64) && (c <= 109) && ((c - 64) % 3 == 0);
            e_vld  = (c >= 66) && (c <= 111) && ((c - 66) % 3 == 0);
            e_done = (c >= 112);
            e_cc   = (c < 64) ? c : 64;
            e_ic   = (c <= 4) ? 0 : ((c >= 64) ? 60 : c - 4);
            n_cmp++; if (core_reset0 !== e_rst) begin n_bad++; $display("FAIL %s core_reset cyc=%0d got=%b exp=%b", tag, c, core_reset0, e_rst); end
            n_cmp++; if (core_halt0 !== e_halt) begin n_bad++; $display("FAIL %s core_halt cyc=%0d got=%b exp=%b", tag, c, core_halt0, e_halt); end
            n_cmp++; if (bus0.reg_rd_en !== e_rd) begin n_bad++; $display("FAIL %s reg_rd_en cyc=%0d got=%b exp=%b", tag, c, bus0.reg_rd_en, e_rd); end
            n_cmp++; if (bus0.dump_valid !== e_vld) begin n_bad++; $display("FAIL %s dump_valid cyc=%0d got=%b exp=%b", tag, c, bus0.dump_valid, e_vld); end
            n_cmp++; if (done0 !== e_done) begin n_bad++; $display("FAIL %s done cyc=%0d got=%b exp=%b", tag, c, done0, e_done); end
            n_cmp++; if (cc0 !== 32'(e_cc)) begin n_bad++; $display("FAIL %s cycle_count cyc=%0d got=%0d exp=%0d", tag, c, cc0, e_cc); end
            n_cmp++; if (ic0 !== 32'(e_ic)) begin n_bad++; $display("FAIL %s insn_count cyc=%0d got=%0d exp=%0d", tag, c, ic0, e_ic); end
            if (e_rd) begin
                e_idx = (c - 64) / 3;
                n_cmp++; if (bus0.reg_idx !== 4'(e_idx)) begin n_bad++; $display("FAIL %s reg_idx cyc=%0d got=%0d exp=%0d", tag, c, bus0.reg_idx, e_idx); end
            end
            if (e_vld) begin
                e_idx = (c - 66) / 3;
                n_cmp++; if (bus0.dump_idx !== 4'(e_idx)) begin n_bad++; $display("FAIL %s dump_idx cyc=%0d got=%0d exp=%0d", tag, c, bus0.dump_idx, e_idx); end
                n_cmp++; if (bus0.dump_data !== 32'h1000 + 32'(e_idx)) begin n_bad++; $display("FAIL %s dump_data cyc=%0d got=%h exp=%h", tag, c, bus0.dump_data, 32'h1000 + 32'(e_idx)); end
            end
            if (c < 115) tick();
        end
    endtask

    // dump_ready withheld for 5 cycles while beat 3 is presented.
    task automatic test_backpressure();
        do_reset();
        retire = 1'b1;
        for (int c = 0; c <= 117; c++) begin
            bus0.dump_ready = !((c >= 75) && (c <= 79));
            if (c >= 75 && c <= 80) begin
                n_cmp++; if (bus0.dump_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid_hold cyc=%0d got=%b exp=1", c, bus0.dump_valid); end
                n_cmp++; if (bus0.dump_idx !== 4'd3) begin n_bad++; $display("FAIL bp_idx_hold cyc=%0d got=%0d exp=3", c, bus0.dump_idx); end
                n_cmp++; if (bus0.dump_data !== 32'h1003) begin n_bad++; $display("FAIL bp_data_hold cyc=%0d got=%h exp=00001003", c, bus0.dump_data); end
                n_cmp++; if (bus0.reg_rd_en !== 1'b0) begin n_bad++; $display("FAIL bp_no_read cyc=%0d got=%b exp=0", c, bus0.reg_rd_en); end
            end
            if (c == 81) begin
                n_cmp++; if (bus0.reg_rd_en !== 1'b1 || bus0.reg_idx !== 4'd4) begin n_bad++; $display("FAIL bp_next_read got rd=%b idx=%0d exp rd=1 idx=4", bus0.reg_rd_en, bus0.reg_idx); end
                n_cmp++; if (bus0.dump_valid !== 1'b0) begin n_bad++; $display("FAIL bp_valid_drop got=%b exp=0", bus0.dump_valid); end
            end
            if (c == 83) begin
                n_cmp++; if (bus0.dump_valid !== 1'b1 || bus0.dump_data !== 32'h1004) begin n_bad++; $display("FAIL bp_beat4 got vld=%b data=%h exp vld=1 data=00001004", bus0.dump_valid, bus0.dump_data); end
            end
            if (c == 116) begin
                n_cmp++; if (done0 !== 1'b0) begin n_bad++; $display("FAIL bp_done_early got=%b exp=0", done0); end
            end
            if (c == 117) begin
                n_cmp++; if (done0 !== 1'b1) begin n_bad++; $display("FAIL bp_done got=%b exp=1", done0); end
            end
            if (c < 117) tick();
        end
        bus0.dump_ready = 1'b1;
    endtask

    // CNTW=4 without dump, and a window shorter than the release delays.
    task automatic test_variants();
        int e1, e_ic1;
        logic e_rd2;
        do_reset();
        retire = 1'b1;
        for (int c = 0; c <= 70; c++) begin
            e1    = (c < 15) ? c : 15;
            e_ic1 = (c <= 4) ? 0 : ((c >= 64) ? 60 : c - 4);
            if (e_ic1 > 15) e_ic1 = 15;
            e_rd2 = (c == 3) || (c == 6);
            n_cmp++; if (cc1 !== 4'(e1)) begin n_bad++; $display("FAIL sat_cycle_count cyc=%0d got=%0d exp=%0d", c, cc1, e1); end
            n_cmp++; if (ic1 !== 4'(e_ic1)) begin n_bad++; $display("FAIL sat_insn_count cyc=%0d got=%0d exp=%0d", c, ic1, e_ic1); end
            n_cmp++; if (done1 !== (c >= 64)) begin n_bad++; $display("FAIL nodump_done cyc=%0d got=%b exp=%b", c, done1, (c >= 64)); end
            n_cmp++; if (bus1.reg_rd_en !== 1'b0) begin n_bad++; $display("FAIL nodump_rd_en cyc=%0d got=%b exp=0", c, bus1.reg_rd_en); end
            n_cmp++; if (core_halt1 !== ((c < 4) || (c >= 64))) begin n_bad++; $display("FAIL nodump_halt cyc=%0d got=%b", c, core_halt1); end
            n_cmp++; if (core_halt2 !== 1'b1) begin n_bad++; $display("FAIL short_halt cyc=%0d got=%b exp=1", c, core_halt2); end
            n_cmp++; if (core_reset2 !== (c < 3)) begin n_bad++; $display("FAIL short_reset cyc=%0d got=%b exp=%b", c, core_reset2, (c < 3)); end
            n_cmp++; if (bus2.reg_rd_en !== e_rd2) begin n_bad++; $display("FAIL short_rd_en cyc=%0d got=%b exp=%b", c, bus2.reg_rd_en, e_rd2); end
            n_cmp++; if (ic2 !== 32'd0) begin n_bad++; $display("FAIL short_insn cyc=%0d got=%0d exp=0", c, ic2); end
            n_cmp++; if (cc2 !== 32'((c < 3) ? c : 3)) begin n_bad++; $display("FAIL short_cycle cyc=%0d got=%0d", c, cc2); end
            n_cmp++; if (done2 !== (c >= 9)) begin n_bad++; $display("FAIL short_done cyc=%0d got=%b exp=%b", c, done2, (c >= 9)); end
            if (c == 8) begin
                n_cmp++; if (bus2.dump_valid !== 1'b1 || bus2.dump_idx !== 4'd1 || bus2.dump_data !== 32'h1001) begin n_bad++; $display("FAIL short_beat1 got vld=%b idx=%0d data=%h", bus2.dump_valid, bus2.dump_idx, bus2.dump_data); end
            end
            if (c < 70) tick();
        end
    endtask

    // Reset hits while beat 7 is valid, then a full rerun must match a fresh run.
    task automatic test_reset_mid_dump();
        do_reset();
        retire = 1'b1;
        bus0.dump_ready = 1'b1;
        while (cyc < 87) tick();
        n_cmp++; if (bus0.dump_valid !== 1'b1 || bus0.dump_idx !== 4'd7) begin n_bad++; $display("FAIL mid_beat7 got vld=%b idx=%0d exp vld=1 idx=7", bus0.dump_valid, bus0.dump_idx); end
        reset = 1'b1;
        tick();
        n_cmp++; if (bus0.dump_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid got=%b exp=0", bus0.dump_valid); end
        n_cmp++; if (bus0.dump_idx !== 4'd0 || bus0.dump_data !== 32'd0) begin n_bad++; $display("FAIL mid_rst_dump got idx=%0d data=%h exp 0/0", bus0.dump_idx, bus0.dump_data); end
        n_cmp++; if (core_reset0 !== 1'b1 || core_halt0 !== 1'b1) begin n_bad++; $display("FAIL mid_rst_core got rst=%b halt=%b exp 1/1", core_reset0, core_halt0); end
        n_cmp++; if (bus0.reg_rd_en !== 1'b0 || bus0.reg_idx !== 4'd0) begin n_bad++; $display("FAIL mid_rst_read got rd=%b idx=%0d exp 0/0", bus0.reg_rd_en, bus0.reg_idx); end
        n_cmp++; if (cc0 !== 32'd0 || ic0 !== 32'd0 || done0 !== 1'b0) begin n_bad++; $display("FAIL mid_rst_counts got cc=%0d ic=%0d done=%b exp 0/0/0", cc0, ic0, done0); end
        reset = 1'b0;
        cyc = 0;
        test_full_run("rerun");
    endtask

    initial begin
        reset = 1'b1;
        retire = 1'b1;
        bus0.dump_ready = 1'b1;
        bus1.dump_ready = 1'b1;
        bus2.dump_ready = 1'b1;
        bus1.reg_data = 32'd0;
        test_reset();
        test_full_run("first");
        test_backpressure();
        test_variants();
        test_reset_mid_dump();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
